// File: rtl/posmat_fetch.sv
// Read-side client of the XF position matrix memory: fetches three 128-bit rows
// into a 3x4 matrix, retries collided reads, and keeps a one-entry matrix cache.
module posmat_fetch (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic [6:0]   reqRow,
    output logic         matValid,
    input  logic         matReady,
    output logic [383:0] matData,
    output logic [6:0]   posmatAAddr,
    output logic         posmatAEnable,
    input  logic [127:0] posmatAData,
    input  logic         posmatAValid,
    input  logic         CPWrite
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [6:0]     curRow_q, curRow_d;
    logic [6:0]     addr_q, addr_d;
    logic           dirty_q, dirty_d;
    logic           cacheValid_q, cacheValid_d;
    logic [6:0]     cacheRow_q, cacheRow_d;
    logic [383:0]   cacheData_q, cacheData_d;
    logic [383:0]   matData_q, matData_d;
    logic           hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= 2'd0;
            curRow_q     <= 7'd0;
            addr_q       <= 7'd0;
            dirty_q      <= 1'b0;
            cacheValid_q <= 1'b0;
            cacheRow_q   <= 7'd0;
            cacheData_q  <= '0;
            matData_q    <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            curRow_q     <= curRow_d;
            addr_q       <= addr_d;
            dirty_q      <= dirty_d;
            cacheValid_q <= cacheValid_d;
            cacheRow_q   <= cacheRow_d;
            cacheData_q  <= cacheData_d;
            matData_q    <= matData_d;
        end
    end

    // A CP write in the lookup cycle may target this very matrix, so it forces a miss.
    assign hit = cacheValid_q && (reqRow == cacheRow_q) && !CPWrite;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        curRow_d     = curRow_q;
        addr_d       = addr_q;
        dirty_d      = dirty_q;
        cacheValid_d = cacheValid_q;
        cacheRow_d   = cacheRow_q;
        cacheData_d  = cacheData_q;
        matData_d    = matData_q;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    curRow_d = reqRow;
                    dirty_d  = 1'b0;
                    if (hit) begin
                        matData_d = cacheData_q;
                        state_d   = DONE;
                    end else begin
                        k_d     = 2'd0;
                        addr_d  = reqRow;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (posmatAValid) begin
                    case (k_q)
                        2'd0:    matData_d[383:256] = posmatAData;
                        2'd1:    matData_d[255:128] = posmatAData;
                        default: matData_d[127:0]   = posmatAData;
                    endcase
                    if (k_q == 2'd2) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        addr_d  = curRow_q + {5'd0, k_q} + 7'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                if (matReady) begin
                    state_d = IDLE;
                    if (!dirty_q && !CPWrite) begin
                        cacheValid_d = 1'b1;
                        cacheRow_d   = curRow_q;
                        cacheData_d  = matData_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (CPWrite) begin
            cacheValid_d = 1'b0;
            if (state_q != IDLE) begin
                dirty_d = 1'b1;
            end
        end
    end

    always_comb begin
        reqReady      = (state_q == IDLE);
        matValid      = (state_q == DONE);
        posmatAEnable = (state_q == ISSUE);
        posmatAAddr   = addr_q;
        matData       = matData_q;
    end

endmodule

// File: doc/posmat_fetch.md
# posmat_fetch

Read-side client of the XF position matrix memory. Accepts a matrix request (first row address), issues three single-row reads on the matrix memory's read port, and retries any row the memory drops because of a colliding CP write. It assembles the rows into one 384-bit 3x4 matrix for the vertex transform stage. A one-entry matrix cache, invalidated by any CP write snooped from the CP bus, lets back-to-back requests for the same matrix skip the memory.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  matrix request valid.
- reqReady  out  1  request accepted when reqValid & reqReady.
- reqRow  in  7  first row address; rows reqRow, reqRow+1, reqRow+2 (mod 128).
- matValid  out  1  assembled matrix available.
- matReady  in  1  consumer takes matrix when matValid & matReady.
- matData  out  384  [383:256] row0, [255:128] row1, [127:0] row2.
- posmatAAddr  out  7  row address to matrix memory read port.
- posmatAEnable  out  1  read request; one-cycle pulse.
- posmatAData  in  128  row data from memory.
- posmatAValid  in  1  high the cycle after an accepted read; low if the read collided with a CP write.
- CPWrite  in  1  snoop of CP bus write strobe to matrix memory.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Row counter k is 2 bits, with values 0..2.
- IDLE:
  - reqReady=1.
  - On accept, latch reqRow into curRow and clear the dirty flag.
  - Cache hit (cacheValid & reqRow==cacheRow & !CPWrite this cycle): load matData from the cache and go to DONE.
  - Otherwise set k=0 and go to ISSUE.
- ISSUE:
  - posmatAEnable=1, posmatAAddr=curRow+k, with 7-bit wrap (127+1=0).
  - Go to WAIT.
- WAIT:
  - posmatAEnable=0.
  - If posmatAValid=1: write posmatAData into row slot k. If k==2 go to DONE; else increment k and go to ISSUE.
  - If posmatAValid=0 (collision): go to ISSUE with the same k. Retries are unbounded.
- DONE:
  - matValid=1; matData is held stable until the handshake.
  - On matReady: go to IDLE. If dirty==0, set cacheValid=1 and cacheRow=curRow, and copy matData into the cache.
- Snoop:
  - A CPWrite=1 in any cycle clears cacheValid.
  - A CPWrite=1 while in ISSUE, WAIT or DONE sets dirty. A dirty matrix is still delivered but never cached.
- reqReady=0 in every state except IDLE. Only one request is outstanding at a time.
- Reset values: state IDLE, reqReady=1, matValid=0, matData=0, posmatAEnable=0, posmatAAddr=0, cacheValid=0, dirty=0, k=0.

## Timing
- Miss latency, with no collisions:
  - accept at cycle 0;
  - ISSUE row0 at c1, capture at c2;
  - row1 at c3/c4;
  - row2 at c5/c6;
  - matValid first high at c7.
- Each collision adds 2 cycles for that row.
- Hit latency: accept at cycle 0, matValid high at c1.
- posmatAEnable is never high in two consecutive cycles. posmatAAddr is registered and valid in the same cycle as posmatAEnable.
- The memory's registered data is sampled only in WAIT and only when posmatAValid=1.
- After the matReady handshake in DONE, the next request can be accepted 1 cycle later, in IDLE.
- reset=1 in any state returns to IDLE on the next edge:
  - an in-flight fetch is abandoned and any late posmatAValid is ignored;
  - the cache is invalidated;
  - matValid drops the cycle after reset is sampled.
- A CPWrite in the same cycle as a hit lookup forces a miss.

## Test plan
- Cold miss: preload rows 5/6/7 = 0x1..1, 0x2..2, 0x3..3; request reqRow=5 -> enables at c1, c3, c5 with addr 5, 6, 7; matValid at c7; matData = {row5,row6,row7}.
- Collision retry: assert CPWrite during the row1 read so posmatAValid=0 -> row 6 is reissued at c5; matValid at c9; the result is not cached (a repeat reqRow=5 misses).
- Cache hit: two consecutive reqRow=12 requests with no CP writes -> the second raises matValid 1 cycle after accept with no posmatAEnable pulse and identical matData.
- Invalidation: request reqRow=12, perform a CP write to any address, request reqRow=12 again -> full 7-cycle fetch returns the new data.
- Wrap and backpressure: reqRow=127 -> reads addr 127, 0, 1. Hold matReady=0 for 10 cycles -> matValid and matData stay stable and reqReady=0 throughout.
- Reset mid-fetch: assert reset in WAIT for row1 -> next cycle state IDLE, reqReady=1, matValid=0; a following request for the same row misses.
